// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: captures the execute beat, resolves branches and overflow traps,
// and hands beats to the memory stage through a 2-entry skid buffer with a registered ready.
module ex_mem_stage #(
  parameter int SIZE  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_equal,
  input  logic             alu_less,
  input  logic [SIZE-1:0]  store_data,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       branch_type,
  input  logic             trap_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_result,
  output logic [SIZE-1:0]  out_store_data,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch_taken,
  output logic             out_trap,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [SIZE-1:0] result;
    logic [SIZE-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch_taken;
    logic            trap;
    logic            zero;
  } beat_t;

  function automatic logic resolve_branch(input logic [2:0] bt, input logic eq, input logic lt);
    logic taken;
    case (bt)
      3'd1:    taken = eq;
      3'd2:    taken = ~eq;
      3'd3:    taken = lt;
      3'd4:    taken = ~lt;
      3'd5:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t            r_state;
  beat_t             r_main;
  beat_t             r_skid;
  logic [CNT_W-1:0]  r_stall;
  beat_t             w_in_beat;
  logic              w_accept;
  logic              w_out_valid;

  // Capture-time decode: a trapped instruction must not commit any architectural write.
  always_comb begin
    w_in_beat              = '0;
    w_in_beat.result       = alu_result;
    w_in_beat.store_data   = store_data;
    w_in_beat.rd           = rd;
    w_in_beat.trap         = alu_overflow & trap_en;
    w_in_beat.reg_write    = reg_write & ~w_in_beat.trap;
    w_in_beat.mem_write    = mem_write & ~w_in_beat.trap;
    w_in_beat.mem_read     = mem_read;
    w_in_beat.branch_taken = resolve_branch(branch_type, alu_equal, alu_less);
    w_in_beat.zero         = alu_zero;
  end

  assign w_out_valid = (r_state != EMPTY);
  assign in_ready    = (r_state != FULL) & ~reset;
  assign w_accept    = in_valid & in_ready;

  // Stage register: main entry feeds the memory stage, skid absorbs one beat of backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_stall <= '0;
    end else begin
      if (w_out_valid && !out_ready)
        r_stall <= sat_inc(r_stall);
      if (flush) begin
        r_state <= EMPTY;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_accept) begin
              r_main  <= w_in_beat;
              r_state <= ONE;
            end
          end
          ONE: begin
            if (w_accept && out_ready) begin
              r_main <= w_in_beat;
            end else if (w_accept) begin
              r_skid  <= w_in_beat;
              r_state <= FULL;
            end else if (out_ready) begin
              r_state <= EMPTY;
            end
          end
          FULL: begin
            if (out_ready) begin
              r_main  <= r_skid;
              r_state <= ONE;
            end
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end

  assign out_valid        = w_out_valid;
  assign out_result       = r_main.result;
  assign out_store_data   = r_main.store_data;
  assign out_rd           = r_main.rd;
  assign out_reg_write    = r_main.reg_write & w_out_valid;
  assign out_mem_read     = r_main.mem_read & w_out_valid;
  assign out_mem_write    = r_main.mem_write & w_out_valid;
  assign out_branch_taken = r_main.branch_taken & w_out_valid;
  assign out_trap         = r_main.trap & w_out_valid;
  assign stall_count      = r_stall;

endmodule
